// File: rtl/ped_request_conditioner.sv
// Pedestrian request conditioner: per-direction synchronizer, debouncer,
// press pulse/counter and a held walk request with post-acknowledge lockout.
// Channel 0 is north, channel 1 is west; the two channels share no state.
module ped_request_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 3,
    parameter int unsigned LOCKOUT_CYCLES  = 8,
    parameter int unsigned CNT_W           = 8
) (
    input  logic             clk_50_mhz,
    input  logic             reset_n,
    input  logic             nrth_pedo_button,
    input  logic             west_pedo_button,
    input  logic             nrth_ack,
    input  logic             west_ack,
    output logic             nrth_req,
    output logic             west_req,
    output logic             nrth_press,
    output logic             west_press,
    output logic [CNT_W-1:0] nrth_press_cnt,
    output logic [CNT_W-1:0] west_press_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_LOCKOUT = 2'd2
    } req_state_e;

    // Lockout counter is loaded with LOCKOUT_CYCLES-1 and counts down to 0.
    localparam int unsigned     LK_W    = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
    localparam logic [LK_W-1:0] LK_INIT = LK_W'((LOCKOUT_CYCLES > 0) ? LOCKOUT_CYCLES - 1 : 0);
    localparam logic [7:0]      DB_LAST = 8'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       btn_raw;
    logic [1:0]       ack_w;
    logic [1:0]       req_w;
    logic [1:0]       press_w;
    logic [CNT_W-1:0] cnt_w [2];

    assign btn_raw = {west_pedo_button, nrth_pedo_button};
    assign ack_w   = {west_ack, nrth_ack};

    for (genvar g = 0; g < 2; g++) begin : g_ch
        logic             sync1_q, sync2_q;
        logic             deb_q, deb_d, deb_prev_q;
        logic [7:0]       db_cnt_q, db_cnt_d;
        logic             press_d, press_q;
        req_state_e       state_q, state_d;
        logic [LK_W-1:0]  lk_q, lk_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;

        // Two-flop synchronizer; idles at the released level (1).
        // NOTE: sequential state is written with non-blocking assignments so every flop samples pre-edge values.
        always_ff @(posedge clk_50_mhz) begin
            if (reset_n) begin
                sync1_q <= 1'b1;
                sync2_q <= 1'b1;
            end else begin
                sync1_q <= btn_raw[g];
                sync2_q <= sync1_q;
            end
        end

        // Debounce: count consecutive samples differing from the level, flip on the last one.
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        always_comb begin
            deb_d    = deb_q;
            db_cnt_d = '0;
            if (sync2_q != deb_q) begin
                if (db_cnt_q == DB_LAST) begin
                    deb_d = sync2_q;
                end else begin
                    db_cnt_d = db_cnt_q + 8'd1;
                end
            end
        end

        // A press is the cycle after the debounced level fell 1->0.
        assign press_d = deb_prev_q & ~deb_q;

        // Request FSM next state: ack dominates a coincident press while pending.
        always_comb begin
            state_d = state_q;
            lk_d    = lk_q;
            case (state_q)
                ST_IDLE: begin
                    if (press_d) state_d = ST_PENDING;
                end
                ST_PENDING: begin
                    if (ack_w[g]) begin
                        if (LOCKOUT_CYCLES == 0) begin
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_LOCKOUT;
                            lk_d    = LK_INIT;
                        end
                    end
                end
                ST_LOCKOUT: begin
                    if (lk_q == '0) state_d = ST_IDLE;
                    else            lk_d    = lk_q - LK_W'(1);
                end
                default: state_d = ST_IDLE;
            endcase
        end

        // Saturating press counter, cleared only by reset.
        always_comb begin
            cnt_d = cnt_q;
            if (press_d && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
        end

        // Debouncer, press pulse, FSM and counter registers.
        always_ff @(posedge clk_50_mhz) begin
            if (reset_n) begin
                deb_q      <= 1'b1;
                deb_prev_q <= 1'b1;
                db_cnt_q   <= '0;
                press_q    <= 1'b0;
                state_q    <= ST_IDLE;
                lk_q       <= '0;
                cnt_q      <= '0;
            end else begin
                deb_q      <= deb_d;
                deb_prev_q <= deb_q;
                db_cnt_q   <= db_cnt_d;
                press_q    <= press_d;
                state_q    <= state_d;
                lk_q       <= lk_d;
                cnt_q      <= cnt_d;
            end
        end

        assign req_w[g]   = (state_q == ST_PENDING);
        assign press_w[g] = press_q;
        assign cnt_w[g]   = cnt_q;
    end

    assign nrth_req       = req_w[0];
    assign west_req       = req_w[1];
    assign nrth_press     = press_w[0];
    assign west_press     = press_w[1];
    assign nrth_press_cnt = cnt_w[0];
    assign west_press_cnt = cnt_w[1];

endmodule

// File: tb/tb_ped_request_conditioner.sv
// Bench for ped_request_conditioner: two instances (default parameters, and
// no-lockout with a 2-bit counter) driven by the same buttons/acks, compared
// every cycle against a window/timestamp reference model.
module tb_ped_request_conditioner;

    localparam int D   = 3;
    localparam int W_B = 2;

    logic clk_50_mhz       = 1'b0;
    logic reset_n          = 1'b1;
    logic nrth_pedo_button = 1'b1;
    logic west_pedo_button = 1'b1;
    logic nrth_ack         = 1'b0;
    logic west_ack         = 1'b0;

    logic           nrth_req_a, west_req_a, nrth_press_a, west_press_a;
    logic [7:0]     nrth_press_cnt_a, west_press_cnt_a;
    logic           nrth_req_b, west_req_b, nrth_press_b, west_press_b;
    logic [W_B-1:0] nrth_press_cnt_b, west_press_cnt_b;

    always #10 clk_50_mhz = ~clk_50_mhz;

    ped_request_conditioner #(.DEBOUNCE_CYCLES(D), .LOCKOUT_CYCLES(8), .CNT_W(8)) dut_a (
        .clk_50_mhz(clk_50_mhz), .reset_n(reset_n),
        .nrth_pedo_button(nrth_pedo_button), .west_pedo_button(west_pedo_button),
        .nrth_ack(nrth_ack), .west_ack(west_ack),
        .nrth_req(nrth_req_a), .west_req(west_req_a),
        .nrth_press(nrth_press_a), .west_press(west_press_a),
        .nrth_press_cnt(nrth_press_cnt_a), .west_press_cnt(west_press_cnt_a)
    );

    ped_request_conditioner #(.DEBOUNCE_CYCLES(D), .LOCKOUT_CYCLES(0), .CNT_W(W_B)) dut_b (
        .clk_50_mhz(clk_50_mhz), .reset_n(reset_n),
        .nrth_pedo_button(nrth_pedo_button), .west_pedo_button(west_pedo_button),
        .nrth_ack(nrth_ack), .west_ack(west_ack),
        .nrth_req(nrth_req_b), .west_req(west_req_b),
        .nrth_press(nrth_press_b), .west_press(west_press_b),
        .nrth_press_cnt(nrth_press_cnt_b), .west_press_cnt(west_press_cnt_b)
    );

    // Reference model, index m: 0 = a.north, 1 = a.west, 2 = b.north, 3 = b.west.
    int lock_len [4] = '{8, 8, 0, 0};
    int cnt_max  [4] = '{255, 255, 3, 3};
    bit dly0 [4];        // raw sample from one edge ago
    bit dly1 [4];        // raw sample from two edges ago (what the debouncer sees)
    bit hist [4][16];    // recent synchronized samples, hist[m][0] newest
    int hv   [4];        // number of valid entries in hist since reset
    bit lvl  [4];
    bit fell [4];
    bit m_press [4];
    bit m_pend  [4];
    int ack_edge [4];
    int m_cnt [4];
    int cyc = 0;

    int n_assert = 0;
    int n_fail   = 0;

    task automatic model_edge();
        bit raw, ack, s, all_diff, in_lockout;
        for (int m = 0; m < 4; m++) begin
            raw = (m % 2 == 0) ? nrth_pedo_button : west_pedo_button;
            ack = (m % 2 == 0) ? nrth_ack : west_ack;
            if (reset_n) begin
                dly0[m] = 1'b1; dly1[m] = 1'b1; hv[m] = 0; lvl[m] = 1'b1;
                fell[m] = 1'b0; m_press[m] = 1'b0; m_pend[m] = 1'b0;
                ack_edge[m] = -1000; m_cnt[m] = 0;
                for (int i = 0; i < 16; i++) hist[m][i] = 1'b1;
            end else begin
                s       = dly1[m];
                dly1[m] = dly0[m];
                dly0[m] = raw;
                m_press[m] = fell[m];
                for (int i = 15; i > 0; i--) hist[m][i] = hist[m][i-1];
                hist[m][0] = s;
                if (hv[m] < 16) hv[m]++;
                // Level flips once the last D samples all disagree with it.
                fell[m] = 1'b0;
                if (hv[m] >= D) begin
                    all_diff = 1'b1;
                    for (int i = 0; i < D; i++) if (hist[m][i] == lvl[m]) all_diff = 1'b0;
                    if (all_diff) begin
                        fell[m] = lvl[m];
                        lvl[m]  = ~lvl[m];
                    end
                end
                // Lockout covers the edges up to ack_edge + lock_len after an ack.
                in_lockout = (cyc <= ack_edge[m] + lock_len[m]);
                if (m_pend[m]) begin
                    if (ack) begin
                        m_pend[m]   = 1'b0;
                        ack_edge[m] = cyc;
                    end
                end else if (!in_lockout && m_press[m]) begin
                    m_pend[m] = 1'b1;
                end
                if (m_press[m] && m_cnt[m] < cnt_max[m]) m_cnt[m]++;
            end
        end
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("a_nrth_req",   32'(nrth_req_a),       32'(m_pend[0]));
        chk("a_west_req",   32'(west_req_a),       32'(m_pend[1]));
        chk("b_nrth_req",   32'(nrth_req_b),       32'(m_pend[2]));
        chk("b_west_req",   32'(west_req_b),       32'(m_pend[3]));
        chk("a_nrth_press", 32'(nrth_press_a),     32'(m_press[0]));
        chk("a_west_press", 32'(west_press_a),     32'(m_press[1]));
        chk("b_nrth_press", 32'(nrth_press_b),     32'(m_press[2]));
        chk("b_west_press", 32'(west_press_b),     32'(m_press[3]));
        chk("a_nrth_cnt",   32'(nrth_press_cnt_a), 32'(m_cnt[0]));
        chk("a_west_cnt",   32'(west_press_cnt_a), 32'(m_cnt[1]));
        chk("b_nrth_cnt",   32'(nrth_press_cnt_b), 32'(m_cnt[2]));
        chk("b_west_cnt",   32'(west_press_cnt_b), 32'(m_cnt[3]));
    endtask

    // Advance n edges; inputs are changed by the caller only at the falling edge.
    task automatic cycles(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk_50_mhz);
            model_edge();
            @(negedge clk_50_mhz);
            check_all();
        end
    endtask

    int hold_n, hold_w;

    initial begin
        // Reset then idle.
        @(negedge clk_50_mhz);
        reset_n = 1'b1;
        cycles(5);
        reset_n = 1'b0;
        cycles(50);

        // Clean north press: pulse and request on the sixth edge.
        nrth_pedo_button = 1'b0;
        cycles(5);
        chk("nrth_press_before_edge6", 32'(nrth_press_a), 32'd0);
        cycles(1);
        chk("nrth_press_edge6", 32'(nrth_press_a), 32'd1);
        chk("nrth_req_edge6",   32'(nrth_req_a),   32'd1);
        cycles(4);
        nrth_pedo_button = 1'b1;
        cycles(12);

        // West glitches: two cycles low, then a pulse between clock edges.
        west_pedo_button = 1'b0;
        cycles(2);
        west_pedo_button = 1'b1;
        cycles(8);
        west_pedo_button = 1'b0;
        #3 west_pedo_button = 1'b1;
        cycles(8);
        chk("west_glitch_cnt", 32'(west_press_cnt_a), 32'd0);

        // Ack north, then a press completing inside the lockout window.
        nrth_ack = 1'b1;
        cycles(1);
        nrth_ack = 1'b0;
        chk("nrth_req_after_ack", 32'(nrth_req_a), 32'd0);
        nrth_pedo_button = 1'b0;
        cycles(6);
        nrth_pedo_button = 1'b1;
        cycles(12);
        nrth_pedo_button = 1'b0;
        cycles(8);
        nrth_pedo_button = 1'b1;
        cycles(10);

        // Ack arriving on the same edge as a new press pulse while pending.
        nrth_pedo_button = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            nrth_ack = (i == 6);
            cycles(1);
        end
        nrth_ack = 1'b0;
        nrth_pedo_button = 1'b1;
        cycles(12);

        // Both buttons in the same cycle, then both acknowledged.
        nrth_pedo_button = 1'b0;
        west_pedo_button = 1'b0;
        cycles(8);
        nrth_pedo_button = 1'b1;
        west_pedo_button = 1'b1;
        cycles(10);
        nrth_ack = 1'b1;
        west_ack = 1'b1;
        cycles(1);
        nrth_ack = 1'b0;
        west_ack = 1'b0;
        cycles(10);

        // Five west presses saturate the 2-bit counter.
        for (int k = 0; k < 5; k++) begin
            west_pedo_button = 1'b0;
            cycles(6);
            west_pedo_button = 1'b1;
            cycles(6);
        end
        chk("b_west_cnt_saturated", 32'(west_press_cnt_b), 32'd3);

        // Reset while north is held mid-debounce, button held through release.
        nrth_pedo_button = 1'b0;
        cycles(4);
        reset_n = 1'b1;
        cycles(3);
        reset_n = 1'b0;
        cycles(12);
        nrth_pedo_button = 1'b1;
        cycles(10);

        // Randomised button hold times and sparse acks.
        hold_n = 1;
        hold_w = 1;
        for (int k = 0; k < 400; k++) begin
            if (--hold_n == 0) begin
                nrth_pedo_button = ~nrth_pedo_button;
                hold_n = int'($urandom_range(1, 9));
            end
            if (--hold_w == 0) begin
                west_pedo_button = ~west_pedo_button;
                hold_w = int'($urandom_range(1, 9));
            end
            nrth_ack = ($urandom_range(0, 5) == 0);
            west_ack = ($urandom_range(0, 5) == 0);
            cycles(1);
        end
        nrth_ack = 1'b0;
        west_ack = 1'b0;
        cycles(5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/ped_request_conditioner.md
Name: ped_request_conditioner

Overview:
- Upstream stage of traffic_light_top.
- Takes the two raw active-low pedestrian buttons (nrth_pedo_button, west_pedo_button), synchronizes and debounces each, and produces a held per-direction walk request.
- The controller consumes the request and returns a one-cycle acknowledge when it serves the walk phase.
- After an acknowledge, a lockout window suppresses re-requests.
- Per-direction saturating press counters are provided for debug.

Parameters:
- DEBOUNCE_CYCLES, 3, consecutive synchronized samples at the new level needed to flip the debounced level (legal range 1..255).
- LOCKOUT_CYCLES, 8, cycles after an acknowledge during which presses do not re-raise the request (0 = no lockout).
- CNT_W, 8, width of each press counter.

Ports:
- clk_50_mhz  in  1  system clock; all logic on rising edge.
- reset_n  in  1  synchronous, active-high reset (1 = reset), sampled on clk_50_mhz.
- nrth_pedo_button  in  1  raw north button, active-low, asynchronous.
- west_pedo_button  in  1  raw west button, active-low, asynchronous.
- nrth_ack  in  1  one-cycle pulse from the controller: north walk served.
- west_ack  in  1  one-cycle pulse from the controller: west walk served.
- nrth_req  out  1  north walk request, held high until acknowledged.
- west_req  out  1  west walk request, held high until acknowledged.
- nrth_press  out  1  one-cycle pulse per debounced north press.
- west_press  out  1  one-cycle pulse per debounced west press.
- nrth_press_cnt  out  CNT_W  saturating count of debounced north presses.
- west_press_cnt  out  CNT_W  saturating count of debounced west presses.

Behaviour:
- The two channels are identical and fully independent; behaviour below applies to each.
- Synchronizer: 2-flop chain; both flops reset to 1 (released).
- Debouncer:
  - Keeps a debounced level (reset 1) and a counter (reset 0).
  - Each cycle the sync output differs from the debounced level, the counter increments.
  - Any cycle it matches, the counter clears to 0.
  - On the DEBOUNCE_CYCLES-th consecutive differing sample, the debounced level flips and the counter clears.
- Press pulse:
  - Registered; high for exactly 1 cycle, on the cycle after the debounced level goes 1->0.
  - Releases (0->1) produce no pulse.
- Latency: counting the first edge that samples raw low as edge 1, press pulse and req rise on edge DEBOUNCE_CYCLES+3 (edge 6 at default).
- Glitches shorter than DEBOUNCE_CYCLES synchronized samples produce no press.
- Request FSM states: IDLE, PENDING, LOCKOUT; reset state IDLE.
  - IDLE: press -> PENDING (req=1 on the same edge as the press pulse). Ack is ignored.
  - PENDING: req=1. Ack -> LOCKOUT with lockout counter = LOCKOUT_CYCLES-1, or -> IDLE directly if LOCKOUT_CYCLES=0; req=0 from the next cycle. Further presses keep PENDING (no queuing).
  - LOCKOUT: req=0. Counter decrements each cycle; at 0 -> IDLE. Presses are ignored for req but still counted. Ack is ignored.
  - Press and ack in the same cycle while PENDING: ack wins -> LOCKOUT; the press is counted but not latched.
  - Press and ack in the same cycle while IDLE: -> PENDING.
- Press counter: increments on each press pulse and saturates at 2^CNT_W-1 (no wrap). It is cleared only by reset.
- Reset: takes effect at the next edge, mid-operation or not.
  - All outputs go to 0 and counters to 0; sync/debounced levels go to 1.
  - A button held through reset is re-debounced after reset deasserts and yields one new press.
- Outputs are reset to 0 during reset.

Test Plan:
- Reset then idle: reset_n=1 for 5 cycles, then 0; buttons=1 -> all req/press=0 and counts=0 for 50 cycles.
- Clean north press: nrth_pedo_button=0 for 10 cycles from edge 1 -> nrth_press high on edge 6 only; nrth_req=1 from edge 6; nrth_press_cnt=1; west outputs stay 0.
- Glitch rejection: west_pedo_button=0 for 2 cycles, also a sub-cycle pulse -> no west_press, west_req=0, count 0.
- Ack and lockout (LOCKOUT_CYCLES=8): with nrth_req=1, pulse nrth_ack -> nrth_req=0 next cycle. A new press completing during the 8-cycle lockout -> count increments, req stays 0. The same press pattern after lockout -> req=1.
- Simultaneous ack and press in PENDING -> LOCKOUT, req=0, count+1. Both channels pressed in the same cycle -> both req rise on the same edge.
- Saturation and reset mid-debounce:
  - With CNT_W=2, 5 presses -> count stops at 3.
  - Assert reset while a button is held at debounce count 2 -> outputs 0. After reset releases with the button still held -> exactly one press on edge DEBOUNCE_CYCLES+3 counted from the first post-reset edge.
